// File: rtl/text_line_renderer_pkg.sv
// Shared constants and types for the text line renderer: glyph codes,
// glyph geometry and the prefetch FSM state encoding.
package text_line_renderer_pkg;

  localparam logic [2:0] GLYPH_F     = 3'd0;
  localparam logic [2:0] GLYPH_Q     = 3'd1;
  localparam logic [2:0] GLYPH_H     = 3'd2;
  localparam logic [2:0] GLYPH_X     = 3'd3;
  localparam logic [2:0] GLYPH_U     = 3'd4;
  localparam logic [2:0] GLYPH_BLANK = 3'd5;

  localparam int GLYPH_ROWS  = 16;
  localparam int GLYPH_WIDTH = 8;
  localparam int NUM_CHARS   = 8;

  localparam int ROW_W = $clog2(GLYPH_ROWS);
  localparam int IDX_W = $clog2(NUM_CHARS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  // Codes above BLANK have no glyph and render as empty cells.
  function automatic logic is_blank_code(input logic [2:0] code);
    return code >= GLYPH_BLANK;
  endfunction

endpackage

// File: rtl/text_line_renderer.sv
// Eight-character text line renderer: prefetches one glyph row per character
// from an external ROM ahead of each scanline, then serves pixels from it.
module text_line_renderer
  import text_line_renderer_pkg::*;
#(
  parameter int ORG_X = 100,
  parameter int ORG_Y = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       line_start,
  input  logic [9:0] next_y,
  input  logic       pixel_en,
  input  logic [9:0] pixel_x,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [2:0] wr_code,
  output logic [6:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       pixel_on
);

  localparam logic [10:0] Y_LO = 11'(ORG_Y);
  localparam logic [10:0] Y_HI = 11'(ORG_Y + GLYPH_ROWS);
  localparam logic [10:0] X_LO = 11'(ORG_X);
  localparam logic [10:0] X_HI = 11'(ORG_X + NUM_CHARS * GLYPH_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   line_active_q, line_active_d;
  logic                   pixel_on_q, pixel_on_d;
  logic [GLYPH_WIDTH-1:0] linebuf_q [NUM_CHARS];
  logic [2:0]             text_q    [NUM_CHARS];

  logic                   linebuf_we;
  logic [2:0]             cur_code;
  logic [GLYPH_WIDTH-1:0] glyph_row;
  logic [10:0]            y_ext, x_ext;
  logic                   y_in_win, x_in_win;
  logic [5:0]             x_off;

  // Window tests are done one bit wider than the inputs so the upper bound
  // cannot wrap for origins near the top of the 10-bit range.
  assign y_ext    = {1'b0, next_y};
  assign y_in_win = (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign x_ext    = {1'b0, pixel_x};
  assign x_in_win = (x_ext >= X_LO) && (x_ext < X_HI);
  assign x_off    = x_ext[5:0] - X_LO[5:0];

  assign cur_code  = text_q[idx_q];
  assign glyph_row = is_blank_code(cur_code) ? '0 : rom_data;
  assign busy      = (state_q == ST_FETCH);
  assign pixel_on  = pixel_on_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    row_d         = row_q;
    line_active_d = line_active_q;
    linebuf_we    = 1'b0;
    rom_addr      = '0;

    if (state_q == ST_FETCH) begin
      rom_addr = {cur_code, row_q};
    end

    if (line_start) begin
      // A new request always invalidates the current line, even mid-fetch.
      line_active_d = 1'b0;
      idx_d         = '0;
      if (y_in_win) begin
        row_d   = next_y[ROW_W-1:0] - Y_LO[ROW_W-1:0];
        state_d = ST_FETCH;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_FETCH) begin
      linebuf_we = 1'b1;
      idx_d      = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        line_active_d = 1'b1;
        state_d       = ST_IDLE;
      end
    end
  end

  assign pixel_on_d = pixel_en & line_active_q & x_in_win &
                      linebuf_q[x_off[5:3]][x_off[2:0]];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      row_q         <= '0;
      line_active_q <= 1'b0;
      pixel_on_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      row_q         <= row_d;
      line_active_q <= line_active_d;
      pixel_on_q    <= pixel_on_d;
    end
  end

  // NOTE: these small register arrays are reset explicitly because blank
  // text and an empty line are visible power-on behaviour, unlike a RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        linebuf_q[i] <= '0;
      end
    end else if (linebuf_we) begin
      linebuf_q[idx_q] <= glyph_row;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        text_q[i] <= GLYPH_BLANK;
      end
    end else if (wr_en) begin
      text_q[wr_idx] <= wr_code;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Self-checking bench for text_line_renderer with a behavioural glyph ROM
// and a slot/pixel level reference model of the rendered line.
module tb_text_line_renderer;

  localparam int ORG_X = 100;
  localparam int ORG_Y = 200;

  logic       clk = 1'b0;
  logic       resetn;
  logic       line_start;
  logic [9:0] next_y;
  logic       pixel_en;
  logic [9:0] pixel_x;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [2:0] wr_code;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy;
  logic       pixel_on;

  int checks = 0;
  int errors = 0;

  // Reference model: text slots, captured glyph rows and line validity.
  logic [2:0] tm [8];
  logic [7:0] lm [8];
  logic       m_active;

  typedef struct {
    int   x;
    logic en;
    logic exp;
  } vec_t;
  vec_t vq [$];

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // Glyph ROM: F has a two-pixel stem with bars on rows 1 and 7, Q row 15 is
  // 10111110, blank is empty, everything else is arbitrary but non-zero-ish.
  function automatic logic [7:0] rom_fn(input logic [2:0] c, input logic [3:0] r);
    int v;
    v = int'(c) * 37 + int'(r) * 29 + 11;
    case (c)
      3'd0: begin
        if (r == 4'd1) return 8'hFF;
        if (r == 4'd7) return 8'h7F;
        if (r >= 4'd1 && r <= 4'd13) return 8'h03;
        return 8'h00;
      end
      3'd1: if (r == 4'd15) return 8'hBE;
      3'd5: return 8'h00;
      default: ;
    endcase
    return 8'(v) ^ 8'h5A;
  endfunction

  assign rom_data = rom_fn(rom_addr[6:4], rom_addr[3:0]);

  text_line_renderer #(.ORG_X(ORG_X), .ORG_Y(ORG_Y)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .line_start(line_start),
    .next_y    (next_y),
    .pixel_en  (pixel_en),
    .pixel_x   (pixel_x),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_code   (wr_code),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .pixel_on  (pixel_on)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_px(input int x, input logic en);
    int o;
    if (!en || !m_active || x < ORG_X || x >= ORG_X + 64) return 1'b0;
    o = x - ORG_X;
    return lm[o / 8][o % 8];
  endfunction

  function automatic logic [7:0] model_row(input logic [2:0] code, input int row);
    if (code > 3'd5) return 8'h00;
    return rom_fn(code, 4'(row));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      tm[i] = 3'd5;
      lm[i] = 8'h00;
    end
    m_active = 1'b0;
  endtask

  task automatic write_text(input int idx, input int code);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_code = 3'(code);
    @(posedge clk);
    tm[idx] = 3'(code);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Requests a prefetch and follows it to completion; optionally writes one
  // text slot during fetch cycle w_cyc (w_cyc < 0 means no write).
  task automatic prefetch(input int y, input int w_cyc, input int w_idx, input int w_code);
    logic       in_win;
    int         row;
    int         cnt;
    logic [7:0] snap [8];
    in_win = (y >= ORG_Y) && (y < ORG_Y + 16);
    row    = y - ORG_Y;
    cnt    = 0;
    @(negedge clk);
    line_start = 1'b1; next_y = 10'(y);
    @(posedge clk);
    @(negedge clk);
    line_start = 1'b0;
    m_active   = 1'b0;
    while (busy === 1'b1 && cnt < 20) begin
      check($sformatf("rom_addr_fetch_c%0d", cnt), 32'(rom_addr),
            32'({tm[cnt % 8], 4'(row)}));
      snap[cnt % 8] = model_row(tm[cnt % 8], row);
      if (cnt == w_cyc) begin
        wr_en = 1'b1; wr_idx = 3'(w_idx); wr_code = 3'(w_code);
      end
      @(posedge clk);
      if (cnt == w_cyc) tm[w_idx] = 3'(w_code);
      @(negedge clk);
      wr_en = 1'b0;
      cnt++;
    end
    check($sformatf("fetch_cycles_y%0d", y), 32'(cnt), in_win ? 32'd8 : 32'd0);
    check("rom_addr_idle", 32'(rom_addr), 32'd0);
    if (in_win && cnt == 8) begin
      for (int i = 0; i < 8; i++) lm[i] = snap[i];
      m_active = 1'b1;
    end
  endtask

  task automatic drive_px(input int x, input logic en, output logic got);
    @(negedge clk);
    pixel_x = 10'(x); pixel_en = en;
    @(posedge clk);
    @(negedge clk);
    got = pixel_on;
  endtask

  task automatic sweep_model(input int x0, input int x1);
    logic got;
    for (int x = x0; x <= x1; x++) begin
      drive_px(x, 1'b1, got);
      check($sformatf("px_model_x%0d", x), 32'(got), 32'(model_px(x, 1'b1)));
    end
  endtask

  task automatic run_table(input string tag);
    logic got;
    foreach (vq[i]) begin
      drive_px(vq[i].x, vq[i].en, got);
      check($sformatf("%s_x%0d_en%0d", tag, vq[i].x, vq[i].en), 32'(got), 32'(vq[i].exp));
    end
    vq.delete();
  endtask

  task automatic add_vec(input int x, input logic en, input logic exp);
    vec_t v;
    v.x = x; v.en = en; v.exp = exp;
    vq.push_back(v);
  endtask

  initial begin
    logic got;
    resetn = 1'b0; line_start = 1'b0; next_y = '0; pixel_en = 1'b0;
    pixel_x = '0; wr_en = 1'b0; wr_idx = '0; wr_code = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pixel_on", 32'(pixel_on), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    resetn = 1'b1;

    // Blank text renders nothing; rom_addr shows code 5 for every slot
    prefetch(202, -1, 0, 0);
    for (int x = 100; x <= 163; x++) add_vec(x, 1'b1, 1'b0);
    run_table("blank");

    // F in slot 0, row 2 = 00000011
    write_text(0, 0);
    prefetch(202, -1, 0, 0);
    add_vec(100, 1'b1, 1'b1);
    add_vec(101, 1'b1, 1'b1);
    for (int x = 102; x <= 107; x++) add_vec(x, 1'b1, 1'b0);
    add_vec(100, 1'b0, 1'b0);
    add_vec(99, 1'b1, 1'b0);
    run_table("f_row2");

    // Q in slot 1, last glyph row 10111110
    write_text(1, 1);
    prefetch(215, -1, 0, 0);
    add_vec(108, 1'b1, 1'b0);
    for (int x = 109; x <= 113; x++) add_vec(x, 1'b1, 1'b1);
    add_vec(114, 1'b1, 1'b0);
    add_vec(115, 1'b1, 1'b1);
    run_table("q_row15");

    // Out-of-window restart during FETCH cycle 3
    @(negedge clk);
    line_start = 1'b1; next_y = 10'd202;
    @(posedge clk);
    @(negedge clk);
    line_start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    line_start = 1'b1; next_y = 10'd199;
    @(posedge clk);
    @(negedge clk);
    line_start = 1'b0;
    m_active = 1'b0;
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'd0);
    for (int x = 100; x <= 115; x++) add_vec(x, 1'b1, 1'b0);
    run_table("abort");

    // Slots F and H, row 7: F shows bits 0..6; window edges stay dark
    write_text(2, 2);
    prefetch(207, -1, 0, 0);
    add_vec(99, 1'b1, 1'b0);
    add_vec(164, 1'b1, 1'b0);
    for (int x = 100; x <= 106; x++) add_vec(x, 1'b1, 1'b1);
    add_vec(107, 1'b1, 1'b0);
    run_table("f_row7");
    sweep_model(96, 167);

    // Write to a slot not yet fetched is used; to a fetched slot it is not
    prefetch(207, 2, 6, 3);
    sweep_model(148, 155);
    prefetch(207, 4, 0, 4);
    sweep_model(100, 107);
    prefetch(207, -1, 0, 0);
    sweep_model(100, 107);

    // Reset during FETCH cycle 5
    write_text(3, 3);
    @(negedge clk);
    line_start = 1'b1; next_y = 10'd202;
    @(posedge clk);
    @(negedge clk);
    line_start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_mid_pixel_on", 32'(pixel_on), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_after_busy", 32'(busy), 32'd0);
      check("rst_after_rom_addr", 32'(rom_addr), 32'd0);
    end
    prefetch(202, -1, 0, 0);
    sweep_model(100, 163);

    // Randomized text, rows, mid-fetch writes and pixels against the model
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) write_text(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      prefetch(int'($urandom_range(194, 221)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      for (int k = 0; k < 24; k++) begin
        int   x;
        logic en;
        x  = int'($urandom_range(92, 172));
        en = ($urandom_range(0, 3) != 0);
        drive_px(x, en, got);
        check($sformatf("rand_it%0d_x%0d", it, x), 32'(got), 32'(model_px(x, en)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
